// File: rtl/amux_seq_ctrl.sv
// Break-before-make sequencing controller for an NCH:1 analog mux: one-hot gates, middle-node grounding, settle timing.
// Optional auto-scan through a channel mask is compiled in when AMUX_AUTOSCAN_EN is defined.
module amux_seq_ctrl #(
    parameter int NCH    = 8,
    parameter int BBM    = 1,
    parameter int SETTLE = 4,
    parameter int DWELL  = 16,
    localparam int CW    = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [CW-1:0]  ch,
    output logic           ack,
    output logic           err,
    output logic           busy,
    output logic           valid,
    output logic [CW-1:0]  cur_ch,
    output logic [NCH-1:0] sel,
    output logic [NCH-1:0] gnd_unsel,
    input  logic           scan_en,
    input  logic [NCH-1:0] scan_mask
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  cur_ch_reg;
    logic [NCH-1:0] sel_reg;
    logic [NCH-1:0] gnd_unsel_reg;
    logic           ack_reg;
    logic           err_reg;
    logic           busy_reg;
    logic           valid_reg;
    logic [7:0]     cnt_reg;

    logic           can_accept;
    logic           ch_bad;
    logic           same_ch;
    logic           ack_now;
    logic           err_now;
    logic           scan_go;
    logic           go_break;
    logic [CW-1:0]  scan_tgt;
    logic [CW-1:0]  break_ch;
    logic [NCH-1:0] cur_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_onehot
            assign cur_onehot[gi] = (cur_ch_reg == CW'(gi));
        end
    endgenerate

    assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);
    assign ch_bad     = ({1'b0, ch} >= (CW + 1)'(NCH));
    assign ack_now    = can_accept && req && !ch_bad;
    assign err_now    = can_accept && req && ch_bad;
    assign same_ch    = (state_reg == ST_HOLD) && (ch == cur_ch_reg);
    // A pending request always beats a scan step, even one that will be rejected.
    assign go_break   = (ack_now && !same_ch) || (!req && scan_go);
    assign break_ch   = req ? ch : scan_tgt;

`ifdef AMUX_AUTOSCAN_EN
    logic [15:0]   dwell_reg;
    logic          dwell_done;
    logic          scan_any;
    logic          scan_hit;
    logic [CW-1:0] scan_first;
    logic [CW-1:0] scan_next;
    logic [CW:0]   scan_idx;

    // Lowest set bit for a cold start; first set bit above the current channel (wrapping) for a step.
    always_comb begin
        scan_first = '0;
        scan_any   = 1'b0;
        scan_next  = '0;
        scan_hit   = 1'b0;
        scan_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (scan_mask[i]) begin
                scan_first = CW'(i);
                scan_any   = 1'b1;
            end
        end
        for (int k = NCH - 1; k >= 1; k--) begin
            scan_idx = {1'b0, cur_ch_reg} + (CW + 1)'(k);
            if (scan_idx >= (CW + 1)'(NCH)) begin
                scan_idx = scan_idx - (CW + 1)'(NCH);
            end
            if (scan_mask[scan_idx[CW-1:0]]) begin
                scan_next = scan_idx[CW-1:0];
                scan_hit  = 1'b1;
            end
        end
    end

    assign dwell_done = (state_reg == ST_HOLD) && scan_en && (dwell_reg == 16'(DWELL - 1));
    assign scan_go    = scan_en && (((state_reg == ST_IDLE) && scan_any) || (dwell_done && scan_hit));
    assign scan_tgt   = (state_reg == ST_IDLE) ? scan_first : scan_next;
`else
    logic unused_scan;
    assign unused_scan = ^{scan_en, scan_mask, 16'(DWELL)};
    assign scan_go     = 1'b0;
    assign scan_tgt    = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cur_ch_reg    <= '0;
            sel_reg       <= '0;
            gnd_unsel_reg <= '1;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            cnt_reg       <= '0;
`ifdef AMUX_AUTOSCAN_EN
            dwell_reg     <= '0;
`endif
        end else begin
            ack_reg <= ack_now;
            err_reg <= err_now;
            if (go_break) begin
                state_reg     <= ST_BREAK;
                cur_ch_reg    <= break_ch;
                sel_reg       <= '0;
                gnd_unsel_reg <= '1;
                busy_reg      <= 1'b1;
                valid_reg     <= 1'b0;
                cnt_reg       <= 8'(BBM - 1);
            end else begin
                case (state_reg)
                    ST_BREAK: begin
                        if (cnt_reg == 8'd0) begin
                            sel_reg       <= cur_onehot;
                            gnd_unsel_reg <= ~cur_onehot;
                            state_reg     <= ST_SETTLE;
                            cnt_reg       <= 8'(SETTLE - 1);
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_reg == 8'd0) begin
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef AMUX_AUTOSCAN_EN
            // Dwell restarts on re-request of the same channel and freezes on a rejected request.
            if ((state_reg != ST_HOLD) || ack_now || !scan_en) begin
                dwell_reg <= '0;
            end else if (!err_now) begin
                dwell_reg <= dwell_done ? 16'd0 : dwell_reg + 16'd1;
            end
`endif
        end
    end

    assign ack       = ack_reg;
    assign err       = err_reg;
    assign busy      = busy_reg;
    assign valid     = valid_reg;
    assign cur_ch    = cur_ch_reg;
    assign sel       = sel_reg;
    assign gnd_unsel = gnd_unsel_reg;

endmodule
